// File: rtl/vga_arb_pkg.sv
// Shared constants, state encoding and the on-screen range test for the VGA plot arbiter.
package vga_arb_pkg;

  localparam int X_LIMIT = 640;
  localparam int Y_LIMIT = 480;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int C_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(X_LIMIT)) && (y < Y_W'(Y_LIMIT));
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side and VGA-side signal bundle for the plot arbiter; names match the VGA core.
interface vga_plot_arbiter_if
  import vga_arb_pkg::*;
#(
  parameter int N_REQ = 3
);

  logic [N_REQ-1:0]     req;
  logic [N_REQ*X_W-1:0] req_x;
  logic [N_REQ*Y_W-1:0] req_y;
  logic [N_REQ*C_W-1:0] req_color;
  logic [N_REQ-1:0]     ack;
  logic [X_W-1:0]       VGA_X;
  logic [Y_W-1:0]       VGA_Y;
  logic [C_W-1:0]       VGA_COLOR;
  logic                 plot;
  logic                 busy;
  logic [7:0]           drop_count;

  modport master (
    output req, req_x, req_y, req_color,
    input  ack, VGA_X, VGA_Y, VGA_COLOR, plot, busy, drop_count
  );

  modport slave (
    input  req, req_x, req_y, req_color,
    output ack, VGA_X, VGA_Y, VGA_COLOR, plot, busy, drop_count
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_grant+1, wrapping.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int idx;

  // NOTE: every output gets a default before the search so no path leaves a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares one VGA plot port among N_REQ pixel requesters: IDLE -> PLOT -> GAP x PLOT_GAP -> IDLE.
module vga_plot_arbiter
  import vga_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int PLOT_GAP = 1
) (
  input logic                CLOCK_50,
  input logic                resetn,
  vga_plot_arbiter_if.slave  bus
);

  localparam int          IDX_W    = $clog2(N_REQ);
  localparam logic [1:0]  S_IDLE   = IDLE;
  localparam logic [1:0]  S_PLOT   = PLOT;
  localparam logic [1:0]  S_GAP    = GAP;
  localparam logic [3:0]  GAP_LOAD = 4'(PLOT_GAP);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [C_W-1:0]   color_q, color_d;
  logic [7:0]       drop_q, drop_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [3:0]       gap_q, gap_d;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [C_W-1:0]   sel_color;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any)
  );

  assign sel_x     = bus.req_x[grant_idx*X_W +: X_W];
  assign sel_y     = bus.req_y[grant_idx*Y_W +: Y_W];
  assign sel_color = bus.req_color[grant_idx*C_W +: C_W];

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    drop_d  = drop_q;
    last_d  = last_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          x_d     = sel_x;
          y_d     = sel_y;
          color_d = sel_color;
          ack_d   = grant;
          plot_d  = in_range(sel_x, sel_y);
          last_d  = grant_idx;
          state_d = S_PLOT;
        end
      end
      S_PLOT: begin
        // plot_q low in PLOT means the captured pixel was off-screen.
        if (!plot_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (PLOT_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      drop_q  <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      drop_q  <= drop_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.plot       = plot_q;
  assign bus.VGA_X      = x_q;
  assign bus.VGA_Y      = y_q;
  assign bus.VGA_COLOR  = color_q;
  assign bus.drop_count = drop_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench: dut_a uses PLOT_GAP=1, dut_b uses PLOT_GAP=0; both three requesters.
module tb_vga_plot_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_plot_arbiter_if #(.N_REQ(3)) bus_a ();
  vga_plot_arbiter_if #(.N_REQ(3)) bus_b ();

  vga_plot_arbiter #(.N_REQ(3), .PLOT_GAP(1)) dut_a (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .bus      (bus_a)
  );

  vga_plot_arbiter #(.N_REQ(3), .PLOT_GAP(0)) dut_b (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .bus      (bus_b)
  );

  task automatic set_px_a(input int i, input int x, input int y, input int c);
    bus_a.req_x[i*10 +: 10]   = 10'(x);
    bus_a.req_y[i*9 +: 9]     = 9'(y);
    bus_a.req_color[i*3 +: 3] = 3'(c);
  endtask

  // Steps to the next cycle with a nonzero ack (sampled 1ns after the edge), up to budget cycles.
  task automatic wait_ack(input bit use_b, input int budget, output logic [2:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      a = use_b ? bus_b.ack : bus_a.ack;
      if (a != 3'b000) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_a.req = '0;
    bus_b.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus_a.ack !== 3'b000 || bus_a.plot !== 1'b0 || bus_a.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_ctrl: ack=%b plot=%b busy=%b want 000/0/0", bus_a.ack, bus_a.plot, bus_a.busy); end
    tests_run++; if (bus_a.VGA_X !== 10'd0 || bus_a.VGA_Y !== 9'd0 || bus_a.VGA_COLOR !== 3'd0 || bus_a.drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_data: x=%0d y=%0d c=%0d drop=%0d want all 0", bus_a.VGA_X, bus_a.VGA_Y, bus_a.VGA_COLOR, bus_a.drop_count); end
    do_reset();
    tests_run++; if (bus_a.busy !== 1'b0 || bus_a.ack !== 3'b000) begin tests_failed++; $display("FAIL reset_idle: busy=%b ack=%b want 0/000", bus_a.busy, bus_a.ack); end
  endtask

  task automatic test_single();
    logic [2:0] a;
    bit ok;
    set_px_a(0, 5, 7, 4);
    bus_a.req = 3'b001;
    @(posedge clk); #1;
    tests_run++; if (bus_a.ack !== 3'b001 || bus_a.plot !== 1'b1) begin tests_failed++; $display("FAIL single_ack: ack=%b plot=%b want 001/1", bus_a.ack, bus_a.plot); end
    tests_run++; if (bus_a.VGA_X !== 10'd5 || bus_a.VGA_Y !== 9'd7 || bus_a.VGA_COLOR !== 3'd4) begin tests_failed++; $display("FAIL single_pixel: x=%0d y=%0d c=%0d want 5/7/4", bus_a.VGA_X, bus_a.VGA_Y, bus_a.VGA_COLOR); end
    tests_run++; if (bus_a.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_plot: busy=%b want 1", bus_a.busy); end
    bus_a.req = 3'b000;
    set_px_a(0, 99, 99, 1);
    @(posedge clk); #1;
    tests_run++; if (bus_a.busy !== 1'b1 || bus_a.plot !== 1'b0 || bus_a.ack !== 3'b000) begin tests_failed++; $display("FAIL single_gap: busy=%b plot=%b ack=%b want 1/0/000", bus_a.busy, bus_a.plot, bus_a.ack); end
    tests_run++; if (bus_a.VGA_X !== 10'd5 || bus_a.VGA_Y !== 9'd7 || bus_a.VGA_COLOR !== 3'd4) begin tests_failed++; $display("FAIL single_hold: x=%0d y=%0d c=%0d want 5/7/4", bus_a.VGA_X, bus_a.VGA_Y, bus_a.VGA_COLOR); end
    @(posedge clk); #1;
    tests_run++; if (bus_a.busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: busy=%b want 0", bus_a.busy); end
    wait_ack(1'b0, 3, a, ok);
    tests_run++; if (ok !== 1'b0) begin tests_failed++; $display("FAIL single_no_req: ack=%b want none", a); end
  endtask

  task automatic test_round_robin();
    logic [2:0] a;
    bit ok;
    int prev;
    do_reset();
    for (int i = 0; i < 3; i++) set_px_a(i, 10 + i, 20 + i, i + 1);
    bus_a.req = 3'b111;
    prev = 0;
    for (int g = 0; g < 9; g++) begin
      wait_ack(1'b0, 6, a, ok);
      tests_run++; if (!ok || a !== 3'(1 << (g % 3)) || bus_a.plot !== 1'b1) begin tests_failed++; $display("FAIL rr_order[%0d]: ack=%b plot=%b want %b/1", g, a, bus_a.plot, 3'(1 << (g % 3))); end
      tests_run++; if (bus_a.VGA_X !== 10'(10 + g % 3)) begin tests_failed++; $display("FAIL rr_x[%0d]: x=%0d want %0d", g, bus_a.VGA_X, 10 + g % 3); end
      if (g > 0) begin
        tests_run++; if (cyc - prev !== 3) begin tests_failed++; $display("FAIL rr_spacing[%0d]: %0d cycles want 3", g, cyc - prev); end
      end
      prev = cyc;
    end
    bus_a.req = 3'b000;
  endtask

  task automatic test_out_of_range();
    logic [2:0] a;
    bit ok;
    int misses;
    do_reset();
    set_px_a(0, 640, 10, 2);
    bus_a.req = 3'b001;
    wait_ack(1'b0, 4, a, ok);
    tests_run++; if (!ok || a !== 3'b001 || bus_a.plot !== 1'b0) begin tests_failed++; $display("FAIL oor_first: ack=%b plot=%b want 001/0", a, bus_a.plot); end
    tests_run++; if (bus_a.drop_count !== 8'd0) begin tests_failed++; $display("FAIL oor_drop_before: drop=%0d want 0", bus_a.drop_count); end
    @(posedge clk); #1;
    tests_run++; if (bus_a.drop_count !== 8'd1) begin tests_failed++; $display("FAIL oor_drop_one: drop=%0d want 1", bus_a.drop_count); end
    misses = 0;
    for (int n = 0; n < 299; n++) begin
      wait_ack(1'b0, 8, a, ok);
      if (!ok) misses++;
    end
    tests_run++; if (misses !== 0) begin tests_failed++; $display("FAIL oor_grants: %0d grants timed out want 0", misses); end
    repeat (2) @(posedge clk); #1;
    tests_run++; if (bus_a.drop_count !== 8'd255) begin tests_failed++; $display("FAIL oor_saturate: drop=%0d want 255", bus_a.drop_count); end
    set_px_a(0, 639, 479, 7);
    wait_ack(1'b0, 4, a, ok);
    tests_run++; if (!ok || bus_a.plot !== 1'b1 || bus_a.VGA_X !== 10'd639 || bus_a.VGA_Y !== 9'd479) begin tests_failed++; $display("FAIL edge_in: plot=%b x=%0d y=%0d want 1/639/479", bus_a.plot, bus_a.VGA_X, bus_a.VGA_Y); end
    set_px_a(0, 0, 480, 7);
    wait_ack(1'b0, 4, a, ok);
    tests_run++; if (!ok || bus_a.plot !== 1'b0 || bus_a.VGA_Y !== 9'd480) begin tests_failed++; $display("FAIL edge_y_out: plot=%b y=%0d want 0/480", bus_a.plot, bus_a.VGA_Y); end
    bus_a.req = 3'b000;
    repeat (2) @(posedge clk); #1;
    tests_run++; if (bus_a.drop_count !== 8'd255) begin tests_failed++; $display("FAIL oor_hold_255: drop=%0d want 255", bus_a.drop_count); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] a;
    bit ok;
    int prev;
    do_reset();
    bus_b.req_x[10 +: 10]  = 10'd100;
    bus_b.req_y[9 +: 9]    = 9'd50;
    bus_b.req_color[3 +: 3] = 3'd3;
    bus_b.req = 3'b010;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack(1'b1, 4, a, ok);
      tests_run++; if (!ok || a !== 3'b010 || bus_b.plot !== 1'b1 || bus_b.VGA_X !== 10'(100 + g)) begin tests_failed++; $display("FAIL b2b[%0d]: ack=%b plot=%b x=%0d want 010/1/%0d", g, a, bus_b.plot, bus_b.VGA_X, 100 + g); end
      if (g > 0) begin
        tests_run++; if (cyc - prev !== 2) begin tests_failed++; $display("FAIL b2b_spacing[%0d]: %0d cycles want 2", g, cyc - prev); end
      end
      prev = cyc;
      bus_b.req_x[10 +: 10] = 10'(101 + g);
    end
    bus_b.req = 3'b000;
  endtask

  task automatic test_reset_abort();
    logic [2:0] a;
    bit ok;
    do_reset();
    set_px_a(0, 3, 4, 5);
    bus_a.req = 3'b001;
    wait_ack(1'b0, 4, a, ok);
    tests_run++; if (!ok || a !== 3'b001) begin tests_failed++; $display("FAIL abort_enter: ack=%b want 001", a); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus_a.plot !== 1'b0 || bus_a.ack !== 3'b000 || bus_a.VGA_X !== 10'd0 || bus_a.VGA_Y !== 9'd0 || bus_a.VGA_COLOR !== 3'd0) begin tests_failed++; $display("FAIL abort_async: plot=%b ack=%b x=%0d y=%0d c=%0d want all 0", bus_a.plot, bus_a.ack, bus_a.VGA_X, bus_a.VGA_Y, bus_a.VGA_COLOR); end
    set_px_a(1, 20, 21, 6);
    set_px_a(2, 30, 31, 1);
    bus_a.req = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b0, 4, a, ok);
    tests_run++; if (!ok || a !== 3'b010 || bus_a.VGA_X !== 10'd20) begin tests_failed++; $display("FAIL abort_first: ack=%b x=%0d want 010/20", a, bus_a.VGA_X); end
    bus_a.req = 3'b110;
    wait_ack(1'b0, 6, a, ok);
    tests_run++; if (!ok || a !== 3'b100 || bus_a.VGA_X !== 10'd30) begin tests_failed++; $display("FAIL abort_second: ack=%b x=%0d want 100/30", a, bus_a.VGA_X); end
    bus_a.req = 3'b000;
  endtask

  initial begin
    bus_a.req = '0; bus_a.req_x = '0; bus_a.req_y = '0; bus_a.req_color = '0;
    bus_b.req = '0; bus_b.req_x = '0; bus_b.req_y = '0; bus_b.req_color = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of pixel requesters (2..8).
REQ-002 SHALL have parameter PLOT_GAP, default 1, idle cycles enforced after each plot cycle (0..15).
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  N_REQ  per-requester pixel request, level, held until acked.
REQ-006 SHALL have port req_x  input  N_REQ*10  packed column per requester; slice i = bits [10i+9:10i].
REQ-007 SHALL have port req_y  input  N_REQ*9  packed row per requester; slice i = bits [9i+8:9i].
REQ-008 SHALL have port req_color  input  N_REQ*3  packed colour (0-7) per requester.
REQ-009 SHALL have port ack  output  N_REQ  one-hot, one-cycle pulse marking capture of that requester's pixel.
REQ-010 SHALL have port VGA_X  output  10  column of the pixel being plotted.
REQ-011 SHALL have port VGA_Y  output  9  row of the pixel being plotted.
REQ-012 SHALL have port VGA_COLOR  output  3  colour of the pixel being plotted.
REQ-013 SHALL have port plot  output  1  one-cycle pulse; pixel drawn when high.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port drop_count  output  8  count of out-of-range requests rejected.

Function
REQ-016 SHALL implement FSM states IDLE, PLOT, GAP.
REQ-017 IDLE with req != 0: on the clock edge SHALL select one requester by round-robin, register its x/y/colour into VGA_X/VGA_Y/VGA_COLOR, set that ack bit, and enter PLOT.
REQ-018 IDLE with req == 0: SHALL remain in IDLE; ack, plot = 0.
REQ-019 Round-robin: search SHALL start at index (last_grant+1) mod N_REQ, ascending with wrap; last_grant updates only on a grant; after reset, index 0 has highest priority.
REQ-020 PLOT lasts exactly one cycle: ack[i] = 1 and plot = 1 if VGA_X < 640 and VGA_Y < 480; otherwise plot = 0 and drop_count increments.
REQ-021 drop_count SHALL saturate at 255.
REQ-022 PLOT SHALL go to GAP when PLOT_GAP > 0, else to IDLE.
REQ-023 GAP SHALL last exactly PLOT_GAP cycles (down-counter), then return to IDLE; req ignored in GAP.
REQ-024 req SHALL NOT be sampled in PLOT or GAP; a requester seeing ack may present its next pixel the following cycle.
REQ-025 Latency: req seen in IDLE at cycle t -> ack/plot high in cycle t+1; back-to-back grants every PLOT_GAP+2 cycles.
REQ-026 With all N_REQ requesting continuously, each SHALL be granted once per N_REQ grants (no starvation).
REQ-027 VGA_X/VGA_Y/VGA_COLOR SHALL hold their last captured values outside PLOT.
REQ-028 Request withdrawn before grant: no ack, no plot, no pointer update.

Reset
REQ-029 resetn low SHALL immediately force: state IDLE, ack = 0, plot = 0, busy = 0, VGA_X = 0, VGA_Y = 0, VGA_COLOR = 0, drop_count = 0, last_grant = N_REQ-1, gap counter = 0.
REQ-030 Reset asserted in PLOT or GAP SHALL abort the operation; the interrupted ack/plot pulse SHALL NOT reappear after release.

Structure
REQ-031 Package vga_arb_pkg SHALL hold X_LIMIT = 640, Y_LIMIT = 480, X_W = 10, Y_W = 9, C_W = 3 and the state enum type.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_grant; outputs grant one-hot, grant_idx, any).

Verification
REQ-033 Single request: req = 001, x = 5, y = 7, colour = 4 -> next cycle ack = 001, plot = 1, VGA_X = 5, VGA_Y = 7, VGA_COLOR = 4; busy for 2 cycles (PLOT_GAP = 1).
REQ-034 All three held high for 9 grants -> ack order 0,1,2,0,1,2,0,1,2, plot pulses 3 cycles apart.
REQ-035 Out of range: x = 640, y = 10 -> ack pulse, plot = 0, drop_count 0 -> 1; 300 such requests -> drop_count = 255.
REQ-036 PLOT_GAP = 0, requester 1 re-requests right after each ack -> plot every 2nd cycle.
REQ-037 resetn low during the PLOT cycle -> plot, ack, VGA_* read 0 immediately; after release with req = 010, first grant goes to requester 1, second to requester 2 when both requesting.
